muldiv_unit: RTL and testbench

Parametrised sequential multiply/divide unit with HI/LO result registers, added beside the ALU in the multicycle datapath to execute MULT, MULTU, DIV, DIVU, MFHI/MFLO (read ports) and MTHI/MTLO (write ports). Iterative shift-add multiply and restoring divide run over WIDTH cycles under a start/busy/done handshake with the control unit. It generalises the fixed 32-bit single-cycle ALU path to any operand width, with multi-cycle operation the ALU does not have.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit: op encoding, FSM states, counter sizing.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    localparam int MULDIV_DEF_WIDTH = 32;
    localparam int MULDIV_CNT_W     = $clog2(MULDIV_DEF_WIDTH);

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; purely combinational, no flow control.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_dat,
    input  logic         neg,
    output logic [W-1:0] out_dat
);

    assign out_dat = neg ? ((~in_dat) + {{(W-1){1'b0}}, 1'b1}) : in_dat;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers; WIDTH+2 cycles start-to-idle.
// start is ignored unless idle (no queueing); divider and div_zero exist only with MULDIV_DIV_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_res_q, neg_res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    op_e                  op_in;
    logic                 signed_op, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step, prod_fix;

    assign op_in     = op_e'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign op_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];

    muldiv_negate #(.W(WIDTH))   u_neg_a    (.in_dat(a),     .neg(a_neg),     .out_dat(a_mag));
    muldiv_negate #(.W(WIDTH))   u_neg_b    (.in_dat(b),     .neg(b_neg),     .out_dat(b_mag));
    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.in_dat(acc_q), .neg(neg_res_q), .out_dat(prod_fix));

    // Multiplier sits in the low half and drains out as the product shifts in from the top.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic                 is_div_q, is_div_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH:0]       rem_sh, trial;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Remainder in the high half, dividend/quotient in the low half.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, mcand_q};
    assign div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    muldiv_negate #(.W(WIDTH)) u_neg_quo (.in_dat(acc_q[WIDTH-1:0]),       .neg(neg_res_q), .out_dat(quo_fix));
    muldiv_negate #(.W(WIDTH)) u_neg_rem (.in_dat(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .out_dat(rem_fix));

    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = CNT_W'(WIDTH - 1);
                    neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    div_zero_d = 1'b0;
                    neg_rem_d  = a_neg;
                    is_div_d   = op_div;
                    if (op_div) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        mcand_d = b_mag;
                        if (b == '0) begin
                            hi_d       = a;
                            lo_d       = '1;
                            div_zero_d = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        state_d = ST_RUN;
                    end
`else
                    if (op_div) begin
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        state_d = ST_RUN;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d = is_div_q ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`else
                {hi_d, lo_d} = prod_fix;
`endif
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q   <= is_div_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] eh, el;
    int          cyc;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // act: 0 plain, 1 re-pulse start mid-run, 2 MTHI/MTLO strobe mid-run
    task automatic run32(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input int act, output int n);
        int extra;
        @(negedge clock);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        check_eq("busy_after_start", busy, 1);
        while (!done && n < 100) begin
            if (act == 1 && n == 5) start = 1'b1;
            if (act == 2 && n == 5) begin
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (act == 2 && n == 10) check_eq("hi_stable_run", hi, eh);
            @(posedge clock); #1;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            n++;
        end
        check_eq("done_seen", done, 1);
        extra = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (done) extra++;
        end
        check_eq("single_done", extra, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb, output int n);
        @(negedge clock);
        start8 = 1'b1; op8 = o; a8 = aa; b8 = bb;
        @(posedge clock); #1;
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("w8_done_seen", done8, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_div_zero", div_zero, 0);
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        @(negedge clock);
        reset = 1'b0;

        run32(2'b00, 32'hFFFF_FFFD, 32'd7, 0, cyc);
        eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFEB;
        check_eq("mult_cycles", cyc, 34);
        check_eq("mult_hi", hi, eh);
        check_eq("mult_lo", lo, el);

        run32(2'b01, 32'hFFFF_FFFF, 32'd2, 1, cyc);
        eh = 32'h0000_0001; el = 32'hFFFF_FFFE;
        check_eq("multu_cycles", cyc, 34);
        check_eq("multu_hi", hi, eh);
        check_eq("multu_lo", lo, el);

        run32(2'b10, 32'hFFFF_FFF9, 32'd2, 0, cyc);
        eh = DIV_EN ? 32'hFFFF_FFFF : eh;
        el = DIV_EN ? 32'hFFFF_FFFD : el;
        check_eq("div_cycles", cyc, DIV_EN ? 34 : 1);
        check_eq("div_hi", hi, eh);
        check_eq("div_lo", lo, el);

        run32(2'b11, 32'd7, 32'd2, 0, cyc);
        eh = DIV_EN ? 32'd1 : eh;
        el = DIV_EN ? 32'd3 : el;
        check_eq("divu_hi", hi, eh);
        check_eq("divu_lo", lo, el);

        run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc);
        eh = DIV_EN ? 32'd0 : eh;
        el = DIV_EN ? 32'h8000_0000 : el;
        check_eq("divmin_hi", hi, eh);
        check_eq("divmin_lo", lo, el);
        check_eq("divmin_flag", div_zero, 0);

        run32(2'b10, 32'd5, 32'd0, 0, cyc);
        eh = DIV_EN ? 32'd5 : eh;
        el = DIV_EN ? 32'hFFFF_FFFF : el;
        check_eq("div0_cycles", cyc, 1);
        check_eq("div0_flag_held", div_zero, DIV_EN);
        check_eq("div0_hi", hi, eh);
        check_eq("div0_lo", lo, el);

        run32(2'b01, 32'd2, 32'd3, 0, cyc);
        eh = 32'd0; el = 32'd6;
        check_eq("div0_flag_cleared", div_zero, 0);
        check_eq("mul23_lo", lo, el);

        @(negedge clock);
        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clock); #1;
        hi_we = 1'b0;
        eh = 32'h0000_1234;
        check_eq("mthi_hi", hi, eh);
        check_eq("mthi_lo_kept", lo, el);

        @(negedge clock);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_00AA;
        @(posedge clock); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        eh = 32'h0000_00AA; el = 32'h0000_00AA;
        check_eq("both_we_hi", hi, eh);
        check_eq("both_we_lo", lo, el);

        run32(2'b01, 32'd4, 32'd4, 2, cyc);
        eh = 32'd0; el = 32'd16;
        check_eq("we_in_run_hi", hi, eh);
        check_eq("we_in_run_lo", lo, el);

        @(negedge clock);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_hi", hi, 0);
        check_eq("midrst_lo", lo, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) cyc++;
        end
        check_eq("midrst_no_done", cyc, 0);

        run8(2'b00, 8'd3, 8'd5, cyc);
        check_eq("w8_cycles", cyc, 10);
        check_eq("w8_hi", hi8, 8'h00);
        check_eq("w8_lo", lo8, 8'h0F);

        run8(2'b00, 8'hFD, 8'd5, cyc);
        check_eq("w8_neg_hi", hi8, 8'hFF);
        check_eq("w8_neg_lo", lo8, 8'hF1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
